// File: rtl/calc_reg_arbiter.sv
// Arbiter for the shared calculator result register: 3 requesters, req/ack handshake, single CE/WE/Di port.
// Grant to ack is HOLD_CYC+1 cycles; losers wait with req held. Define ARB_ROUND_ROBIN_EN for round-robin, else fixed 0>1>2.
module calc_reg_arbiter #(
    parameter int DATA_W   = 32,
    parameter int HOLD_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        req,
    input  logic [2:0]        we_req,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] wdata2,
    output logic [2:0]        gnt,
    output logic [2:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              reg_ce,
    output logic              reg_we,
    output logic [DATA_W-1:0] reg_di,
    input  logic [DATA_W-1:0] reg_do
);

    localparam int HOLD_EFF = (HOLD_CYC < 1) ? 1 : HOLD_CYC;
    localparam int CNT_W    = (HOLD_EFF > 1) ? $clog2(HOLD_EFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_EFF - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP,
        S_RELEASE
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_win;
    logic                r_is_wr;
    logic [2:0]          r_gnt;
    logic [2:0]          r_ack;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_busy;
    logic                r_ce;
    logic                r_we;
    logic [DATA_W-1:0]   r_di;

    logic [1:0]          w_win;
    logic [DATA_W-1:0]   w_wdata;

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] r_last;

    // Scan last+3 down to last+1 so the earliest requester in the rotation wins.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            idx = 2'((int'(last) + k) % 3);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    always_comb begin
        w_win = rr_pick(req, r_last);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= 2'd2;
        end else if (r_state == S_IDLE && |req) begin
            r_last <= w_win;
        end
    end
`else
    always_comb begin
        if (req[0])      w_win = 2'd0;
        else if (req[1]) w_win = 2'd1;
        else             w_win = 2'd2;
    end
`endif

    always_comb begin
        case (w_win)
            2'd0:    w_wdata = wdata0;
            2'd1:    w_wdata = wdata1;
            default: w_wdata = wdata2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_win   <= 2'd0;
            r_is_wr <= 1'b0;
            r_gnt   <= 3'b000;
            r_ack   <= 3'b000;
            r_rdata <= '0;
            r_busy  <= 1'b0;
            r_ce    <= 1'b0;
            r_we    <= 1'b0;
            r_di    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_win   <= w_win;
                        r_is_wr <= we_req[w_win];
                        r_gnt   <= 3'b001 << w_win;
                        r_ce    <= 1'b1;
                        r_we    <= we_req[w_win];
                        r_di    <= w_wdata;
                        r_cnt   <= CNT_LOAD;
                        r_busy  <= 1'b1;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // CE/WE/Di stay frozen so the register's falling-edge write lands inside the window.
                    if (r_cnt == '0) begin
                        if (!r_is_wr) r_rdata <= reg_do;
                        r_ce    <= 1'b0;
                        r_we    <= 1'b0;
                        r_ack   <= r_gnt;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_ack   <= 3'b000;
                    r_gnt   <= 3'b000;
                    r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    // Wait for the winner to drop req so one assertion is served once.
                    if (!req[r_win]) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt    = r_gnt;
    assign ack    = r_ack;
    assign rdata  = r_rdata;
    assign busy   = r_busy;
    assign reg_ce = r_ce;
    assign reg_we = r_we;
    assign reg_di = r_di;

endmodule

// File: tb/tb_calc_reg_arbiter.sv
// Bench for calc_reg_arbiter: directed table, multi-cycle corner sequences, then random traffic vs a timestamp model.
module tb_calc_reg_arbiter;
    localparam int DW = 32;
    localparam int H  = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    req, we_req;
    logic [DW-1:0] wd [3];
    logic [2:0]    gnt, ack;
    logic [DW-1:0] rdata, reg_di, reg_do;
    logic          busy, reg_ce, reg_we;
    logic [DW-1:0] phys_reg = '0;

    always #5 clk = ~clk;

    calc_reg_arbiter #(.DATA_W(DW), .HOLD_CYC(H)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we_req(we_req),
        .wdata0(wd[0]), .wdata1(wd[1]), .wdata2(wd[2]),
        .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy),
        .reg_ce(reg_ce), .reg_we(reg_we), .reg_di(reg_di), .reg_do(reg_do)
    );

    // The result register itself: writes on the falling edge while CE and WE are high.
    always @(negedge clk) if (reg_ce && reg_we) phys_reg <= reg_di;
    assign reg_do = phys_reg;

    int n_pass = 0;
    int n_chk  = 0;
    bit chk_en = 1'b0;

    function automatic void check(string name, logic [DW-1:0] got, logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endfunction

    // Transaction-level reference: a grant at edge ge owns the port for H cycles,
    // acks in the cycle after edge ge+H, and frees at the first edge >= ge+H+2 with req low.
    bit            m_act = 1'b0;
    int            m_ge = 0, e_cnt = 0, m_d = 0;
    logic [1:0]    m_w = 2'd0, m_last = 2'd2;
    bit            m_we = 1'b0;
    logic [DW-1:0] m_wd = '0, m_mem = '0, m_rdata = '0, m_di = '0;

    function automatic logic [1:0] m_pick(logic [2:0] r, logic [1:0] last);
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 3; k++) begin
            int idx = (int'(last) + k) % 3;
            if (r[idx]) return 2'(idx);
        end
`else
        for (int i = 0; i < 3; i++) if (r[i] && last <= 2'd3) return 2'(i);
`endif
        return 2'd0;
    endfunction

    always @(posedge clk) begin
        e_cnt++;
        if (m_act && m_we && (e_cnt - 1 - m_ge) < H) m_mem = m_wd;
        if (!rst_n) begin
            m_act = 1'b0; m_rdata = '0; m_di = '0; m_last = 2'd2;
        end else if (!m_act) begin
            if (|req) begin
                m_w = m_pick(req, m_last);
                m_last = m_w;
                m_act = 1'b1;
                m_ge = e_cnt;
                m_we = we_req[m_w];
                m_wd = wd[m_w];
                m_di = m_wd;
            end
        end else begin
            if (e_cnt == m_ge + H && !m_we) m_rdata = m_mem;
            if (e_cnt >= m_ge + H + 2 && !req[m_w]) m_act = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            m_d = e_cnt - m_ge;
            check("busy",   DW'(busy),   DW'(m_act));
            check("gnt",    DW'(gnt),    (m_act && m_d <= H) ? DW'(3'b001 << m_w) : '0);
            check("ack",    DW'(ack),    (m_act && m_d == H) ? DW'(3'b001 << m_w) : '0);
            check("reg_ce", DW'(reg_ce), DW'(m_act && m_d < H));
            check("reg_we", DW'(reg_we), DW'(m_act && m_d < H && m_we));
            check("rdata",  rdata,       m_rdata);
            if (m_act && m_d < H) check("reg_di", reg_di, m_di);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int            id;
        bit            we;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_reg;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t tbl[6];

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_txn(int id, bit we, logic [DW-1:0] d, output int lat);
        req[id] = 1'b1; we_req[id] = we; wd[id] = d;
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (ack[id]) break;
        end
        if (lat >= 50) check("txn_ack_timeout", 32'd0, 32'd1);
        req[id] = 1'b0;
    endtask

    int lat, n_ack, n_ce, cycles, wins, exp_win;
    int hold[3];
    bit seen[3];
    bit got_ack;

    initial begin
        rst_n = 1'b0; req = '0; we_req = '0;
        wd[0] = '0; wd[1] = '0; wd[2] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_busy", DW'(busy), '0);
        check("reset_rdata", rdata, '0);
        rst_n = 1'b1;
        cyc(2);

        tbl[0] = '{1, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0};
        tbl[1] = '{2, 1'b0, 32'h1111_1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tbl[2] = '{0, 1'b1, 32'd13,        32'd13,        32'hDEAD_BEEF};
        tbl[3] = '{1, 1'b0, 32'h2222_2222, 32'd13,        32'd13};
        tbl[4] = '{2, 1'b1, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'd13};
        tbl[5] = '{0, 1'b0, 32'h3333_3333, 32'hA5A5_5A5A, 32'hA5A5_5A5A};
        for (int i = 0; i < 6; i++) begin
            do_txn(tbl[i].id, tbl[i].we, tbl[i].d, lat);
            check("txn_latency", DW'(lat), DW'(H + 1));
            cyc(2);
            check("txn_reg", phys_reg, tbl[i].exp_reg);
            check("txn_rdata", rdata, tbl[i].exp_rdata);
        end

        // Reset in the middle of a read access.
        req[2] = 1'b1; we_req[2] = 1'b0;
        cyc(2);
        check("mid_ce", DW'(reg_ce), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_ce", DW'(reg_ce), '0);
        check("rst_gnt", DW'(gnt), '0);
        check("rst_busy", DW'(busy), '0);
        check("rst_rdata", rdata, '0);
        check("rst_reg_kept", phys_reg, 32'hA5A5_5A5A);
        rst_n = 1'b1; req = '0;
        cyc(2);

        // Held request: one ack only, busy stays up in RELEASE.
        req[0] = 1'b1; we_req[0] = 1'b1; wd[0] = 32'h0000_0042;
        n_ack = 0; cycles = 0;
        while (n_ack == 0 && cycles < 50) begin
            @(negedge clk); cycles++;
            if (ack[0]) n_ack++;
        end
        repeat (10) begin
            @(negedge clk);
            if (ack[0]) n_ack++;
        end
        check("held_ack_count", DW'(n_ack), 32'd1);
        check("held_busy", DW'(busy), 32'd1);
        req[0] = 1'b0;
        @(negedge clk);
        check("held_release", DW'(busy), '0);
        cyc(1);

        // Write whose req falls in the second ACCESS cycle.
        req[0] = 1'b1; we_req[0] = 1'b1; wd[0] = 32'h0BAD_F00D;
        n_ce = 0; cycles = 0; got_ack = 1'b0;
        while (!got_ack && cycles < 30) begin
            @(negedge clk); cycles++;
            if (reg_ce) n_ce++;
            if (n_ce == 2) req[0] = 1'b0;
            if (ack[0]) got_ack = 1'b1;
        end
        check("drop_ack", DW'(got_ack), 32'd1);
        check("drop_ce_cycles", DW'(n_ce), DW'(H));
        @(negedge clk);
        check("drop_busy_release", DW'(busy), 32'd1);
        @(negedge clk);
        check("drop_idle", DW'(busy), '0);
        check("drop_reg", phys_reg, 32'h0BAD_F00D);

        // Contention: all three hold write requests, each releases briefly after its ack.
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b1; we_req[i] = 1'b1; wd[i] = 32'hC000_0000 + DW'(i); hold[i] = 0;
        end
        wins = 0; cycles = 0;
        while (wins < 6 && cycles < 200) begin
            @(negedge clk); cycles++;
            for (int i = 0; i < 3; i++) begin
                if (ack[i]) begin
`ifdef ARB_ROUND_ROBIN_EN
                    exp_win = wins % 3;
`else
                    exp_win = 0;
`endif
                    check("contention_winner", DW'(i), DW'(exp_win));
                    wins++;
                    req[i] = 1'b0; hold[i] = 2;
                    wd[i] = wd[i] + 32'h100;
                end else if (hold[i] > 0) begin
                    hold[i]--;
                    if (hold[i] == 0) req[i] = 1'b1;
                end
            end
        end
        check("contention_grants", DW'(wins), 32'd6);
        req = '0;
        cyc(4);

        // Random traffic; the negedge checker compares every cycle.
        for (int i = 0; i < 3; i++) seen[i] = 1'b0;
        repeat (3000) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req[i] = 1'b1; we_req[i] = 1'($urandom); wd[i] = $urandom; seen[i] = 1'b0;
                    end
                end else begin
                    if (ack[i]) seen[i] = 1'b1;
                    if (gnt[i]) begin
                        we_req[i] = 1'($urandom); wd[i] = $urandom;
                    end
                    if ((seen[i] && $urandom_range(0, 1) == 0) || (gnt[i] && $urandom_range(0, 9) == 0))
                        req[i] = 1'b0;
                end
            end
            rst_n = ($urandom_range(0, 299) != 0);
        end
        rst_n = 1'b1; req = '0;
        cyc(6);
        check("final_idle", DW'(busy), '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
